fw_done_mon: RTL
================

FW_DONE_MON -- requirements
Module: fw_done_mon

Interface
REQ-001 SHALL have parameter NCH, default 2, number of monitored port channels (1..8).
REQ-002 SHALL have parameter DW, default 8, width of each monitored port value.
REQ-003 SHALL have parameter PASS_CODE, default 8'hEF, value that signals FW task done.
REQ-004 SHALL have parameter FAIL_CODE, default 8'hEE, value that signals FW task failure.
REQ-005 SHALL have parameter STABLE, default 4, consecutive cycles a code must hold before it is accepted (>=1).
REQ-006 SHALL have parameter TOW, default 24, width of the timeout/elapsed counter.
REQ-007 SHALL have ports: clkcpu input 1, CPU clock, all logic on its rising edge.
REQ-008 SHALL have ports: rst input 1, synchronous active-high reset.
REQ-009 SHALL have ports: start input 1, single-cycle request to arm the monitor.
REQ-010 SHALL have ports: port_val input NCH*DW, channel i at bits [i*DW +: DW].
REQ-011 SHALL have ports: ch_en input NCH, channel enable, sampled at start.
REQ-012 SHALL have ports: timeout_lim input TOW, cycle limit, 0 = no timeout, sampled at start.
REQ-013 SHALL have ports: hold_fetch output 1, high blocks CPU program fetch until armed.
REQ-014 SHALL have ports: busy, done, pass, fail, timeout outputs 1 each, status.
REQ-015 SHALL have ports: ch_pass, ch_fail outputs NCH each, per-channel sticky results.
REQ-016 SHALL have ports: elapsed output TOW, cycles spent in RUN.

Function
REQ-017 SHALL implement FSM IDLE -> ARM -> RUN -> DONE, with DONE -> ARM on start.
REQ-018 SHALL in IDLE drive hold_fetch=1 and ignore port_val.
REQ-019 SHALL on start in IDLE or DONE: latch ch_en and timeout_lim, clear ch_pass/ch_fail/elapsed/done/pass/fail/timeout, enter ARM next cycle.
REQ-020 SHALL in ARM drive hold_fetch=0 (stays 0 until reset), clear stable counters, and enter RUN after exactly one cycle.
REQ-021 SHALL ignore start while in ARM or RUN.
REQ-022 SHALL keep busy=1 exactly in ARM and RUN.
REQ-023 SHALL in RUN increment elapsed by 1 per cycle, saturating at all-ones.
REQ-024 SHALL keep per channel a counter of consecutive RUN cycles in which port_val equals one code. The counter resets to 1 when the code changes between PASS_CODE and FAIL_CODE. It resets to 0 on any other value.
REQ-025 SHALL set ch_pass[i] (or ch_fail[i]) on the cycle the counter reaches STABLE with PASS_CODE (or FAIL_CODE), only for enabled channels; results are sticky until the next start.
REQ-026 SHALL ignore later port changes on a channel once its result is latched.
REQ-027 SHALL leave ch_pass and ch_fail of disabled channels at 0.
REQ-028 SHALL enter DONE on the cycle after every enabled channel has a result, setting done=1, fail=|ch_fail, pass=~fail.
REQ-029 SHALL, if ch_en latched all zero, enter DONE after one RUN cycle with pass=1.
REQ-030 SHALL, when timeout_lim!=0 and elapsed==timeout_lim in RUN, enter DONE with timeout=1, done=1, pass=0, fail=|ch_fail.
REQ-031 SHALL give completion priority over timeout when both occur in the same cycle, so timeout=0.
REQ-032 SHALL hold all status outputs and elapsed stable in DONE until start or rst.

Reset
REQ-033 SHALL, on rst=1 at a clkcpu edge in any state, go to IDLE with hold_fetch=1, busy=0, done=0, pass=0, fail=0, timeout=0, ch_pass=0, ch_fail=0, elapsed=0, and counters 0.
REQ-034 SHALL give rst priority over start in the same cycle.

Verification
REQ-035 SHALL verify: NCH=2, ch_en=2'b01, start, then ch0=8'hEF held 4 cycles -> ch_pass=2'b01, done=1, pass=1, elapsed=5.
REQ-036 SHALL verify: ch0=8'hEF for 3 cycles, then 8'h00, then 8'hEF for 4 cycles -> acceptance only after the second run; no early done.
REQ-037 SHALL verify: ch_en=2'b11, ch0 PASS, ch1 FAIL (8'hEE) stable -> ch_pass=01, ch_fail=10, fail=1, pass=0.
REQ-038 SHALL verify: timeout_lim=10, no codes -> done=1, timeout=1, pass=0 on the cycle after elapsed=10. A second case accepts the last channel exactly at elapsed=10 and requires timeout=0.
REQ-039 SHALL verify: hold_fetch=1 from reset until ARM, then 0. rst asserted mid-RUN returns all outputs to reset values on the next edge.
REQ-040 SHALL verify: start during RUN is ignored; start in DONE clears results and re-arms with ch_en=0 -> pass=1 after 2 cycles.

Source files
------------

// File: rtl/fw_done_mon.sv
// Firmware completion monitor: watches per-channel port codes during RUN and reports
// pass/fail/timeout once every enabled channel has held a PASS or FAIL code long enough.
module fw_done_mon #(
  parameter int unsigned       NCH       = 2,
  parameter int unsigned       DW        = 8,
  parameter logic [DW-1:0]     PASS_CODE = 8'hEF,
  parameter logic [DW-1:0]     FAIL_CODE = 8'hEE,
  parameter int unsigned       STABLE    = 4,
  parameter int unsigned       TOW       = 24
) (
  input  logic                clkcpu,
  input  logic                rst,
  input  logic                start,
  input  logic [NCH*DW-1:0]   port_val,
  input  logic [NCH-1:0]      ch_en,
  input  logic [TOW-1:0]      timeout_lim,
  output logic                hold_fetch,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [NCH-1:0]      ch_pass,
  output logic [NCH-1:0]      ch_fail,
  output logic [TOW-1:0]      elapsed
);

  localparam int unsigned    CW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0]  STABLE_C = CW'(STABLE);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  state_e                  state_q;
  logic [NCH-1:0]          en_q;
  logic [TOW-1:0]          lim_q;
  logic [NCH-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]          last_pass_q, last_pass_d;
  logic [NCH-1:0]          hit_pass, hit_fail;
  logic                    all_done, tmo_hit;
  logic [TOW-1:0]          elapsed_inc;

  // Per-channel run-length of a single code; switching between the two codes restarts at 1.
  always_comb begin
    cnt_d       = cnt_q;
    last_pass_d = last_pass_q;
    hit_pass    = '0;
    hit_fail    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (port_val[i*DW +: DW] == PASS_CODE || port_val[i*DW +: DW] == FAIL_CODE) begin
        last_pass_d[i] = (port_val[i*DW +: DW] == PASS_CODE);
        if (cnt_q[i] != '0 && last_pass_q[i] == last_pass_d[i]) begin
          cnt_d[i] = (cnt_q[i] == STABLE_C) ? cnt_q[i] : cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i] = CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
      if (en_q[i] && !ch_pass[i] && !ch_fail[i] && cnt_d[i] == STABLE_C) begin
        hit_pass[i] = last_pass_d[i];
        hit_fail[i] = !last_pass_d[i];
      end
    end
  end

  assign all_done    = &(ch_pass | ch_fail | ~en_q);
  assign tmo_hit     = (lim_q != '0) && (elapsed == lim_q);
  assign elapsed_inc = (&elapsed) ? elapsed : elapsed + 1'b1;

  always_ff @(posedge clkcpu) begin
    if (rst) begin
      state_q     <= StIdle;
      en_q        <= '0;
      lim_q       <= '0;
      cnt_q       <= '0;
      last_pass_q <= '0;
      hold_fetch  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      ch_pass     <= '0;
      ch_fail     <= '0;
      elapsed     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StArm;
            en_q       <= ch_en;
            lim_q      <= timeout_lim;
            hold_fetch <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            ch_pass    <= '0;
            ch_fail    <= '0;
            elapsed    <= '0;
          end
        end
        StArm: begin
          cnt_q       <= '0;
          last_pass_q <= '0;
          state_q     <= StRun;
        end
        StRun: begin
          elapsed     <= elapsed_inc;
          cnt_q       <= cnt_d;
          last_pass_q <= last_pass_d;
          ch_pass     <= ch_pass | hit_pass;
          ch_fail     <= ch_fail | hit_fail;
          // Completion wins over a timeout landing on the same cycle.
          if (all_done) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            fail    <= |ch_fail;
            pass    <= ~|ch_fail;
          end else if (tmo_hit) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            fail    <= |(ch_fail | hit_fail);
            pass    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
